// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and width helpers for the reset sequencer
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int cnt_width(input int min_assert, input int gap_cyc, input int timeout_cyc);
    return clog2(max3(min_assert, gap_cyc, timeout_cyc) + 1);
  endfunction

  function automatic int idx_width(input int num_ch);
    return (num_ch > 1) ? clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/reset_req_sync.sv
// rtl/reset_req_sync.sv - flop chain bringing the asynchronous reset request into the clock domain
module reset_req_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Flops come out of reset at 1 so the request stays asserted until a clean 0 shifts through.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - asserts all channel resets together, releases them one by one in index order
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ASSERT  = 8,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rst_req_async,
  input  logic              sw_rst_req,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              seq_busy,
  output logic              seq_done,
  output logic [NUM_CH-1:0] err_timeout
);

  localparam int CNT_W = cnt_width(MIN_ASSERT, GAP_CYC, TIMEOUT_CYC);
  localparam int IDX_W = idx_width(NUM_CH);

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic             TO_EN    = (TIMEOUT_CYC != 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  seq_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [NUM_CH-1:0] ch_rst_n_nxt;
  logic [NUM_CH-1:0] err_nxt;
  logic              seq_done_nxt;
  logic              req_sync;
  logic              req;
  logic              timeout;
  logic              advance;

  reset_req_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clock(clock),
    .reset(reset),
    .din  (rst_req_async),
    .dout (req_sync)
  );

  assign req = req_sync | sw_rst_req;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    ch_rst_n_nxt = ch_rst_n;
    err_nxt      = err_timeout;
    seq_done_nxt = 1'b0;
    cnt_inc      = (&cnt) ? cnt : cnt + CNT_W'(1);
    timeout      = 1'b0;
    advance      = 1'b0;

    // A request wins over any advance evaluated in the same cycle.
    if (req) begin
      state_nxt    = ST_HOLD;
      cnt_nxt      = '0;
      idx_nxt      = '0;
      ch_rst_n_nxt = '0;
    end else begin
      case (state)
        ST_HOLD: begin
          ch_rst_n_nxt = '0;
          if (cnt == MIN_LAST) begin
            ch_rst_n_nxt = NUM_CH'(1);
            idx_nxt      = '0;
            cnt_nxt      = '0;
            state_nxt    = ST_WAIT;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        ST_WAIT: begin
          timeout = TO_EN && (cnt == TO_LAST) && !ch_ready[idx];
          advance = (ch_ready[idx] && (cnt >= GAP_LAST)) || timeout;
          if (timeout) err_nxt[idx] = 1'b1;
          if (advance) begin
            cnt_nxt = '0;
            if (idx == LAST_IDX) begin
              state_nxt    = ST_RUN;
              seq_done_nxt = 1'b1;
            end else begin
              idx_nxt = idx + IDX_W'(1);
              for (int i = 0; i < NUM_CH; i++) begin
                if (i == int'(idx) + 1) ch_rst_n_nxt[i] = 1'b1;
              end
            end
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        ST_RUN: begin
          ch_rst_n_nxt = '1;
        end
        default: begin
          state_nxt    = ST_HOLD;
          cnt_nxt      = '0;
          idx_nxt      = '0;
          ch_rst_n_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      idx         <= '0;
      ch_rst_n    <= '0;
      seq_busy    <= 1'b1;
      seq_done    <= 1'b0;
      err_timeout <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      ch_rst_n    <= ch_rst_n_nxt;
      seq_busy    <= ~&ch_rst_n_nxt;
      seq_done    <= seq_done_nxt;
      err_timeout <= err_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer with a stage-count reference model
module tb_reset_sequencer;

  localparam int N   = 3;
  localparam int S   = 2;
  localparam int MIN = 4;
  localparam int GAP = 2;
  localparam int TO  = 16;

  logic         clock;
  logic         reset;
  logic         rst_req_async;
  logic         sw_rst_req;
  logic [N-1:0] ch_ready;
  logic [N-1:0] ch_rst_n;
  logic         seq_busy;
  logic         seq_done;
  logic [N-1:0] err_timeout;

  int compared;
  int mismatched;
  bit cmp_en;

  reset_sequencer #(
    .NUM_CH     (N),
    .SYNC_STAGES(S),
    .MIN_ASSERT (MIN),
    .GAP_CYC    (GAP),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rst_req_async(rst_req_async),
    .sw_rst_req   (sw_rst_req),
    .ch_ready     (ch_ready),
    .ch_rst_n     (ch_rst_n),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .err_timeout  (err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = channels released so far (0 = holding, N = all out), k = N+1 once the sequence has finished.
  int           hist [S];
  int           k;
  int           tmr;
  logic [N-1:0] m_err;
  logic         m_done;
  logic         m_req;
  logic         m_to;
  logic         m_adv;

  function automatic logic [N-1:0] exp_ch(input int kk);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (i < kk) v[i] = 1'b1;
    return v;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < S; i++) hist[i] = 1;
      k = 0; tmr = 0; m_err = '0; m_done = 1'b0;
    end else begin
      m_req = (hist[S-1] != 0) || sw_rst_req;
      for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(rst_req_async);
      m_done = 1'b0;
      if (m_req) begin
        k = 0; tmr = 0;
      end else if (k == 0) begin
        if (tmr == MIN - 1) begin k = 1; tmr = 0; end
        else tmr++;
      end else if (k <= N) begin
        m_to  = (TO != 0) && (tmr == TO - 1) && !ch_ready[k-1];
        m_adv = (ch_ready[k-1] && tmr >= GAP - 1) || m_to;
        if (m_to) m_err[k-1] = 1'b1;
        if (m_adv) begin
          k++; tmr = 0;
          if (k == N + 1) m_done = 1'b1;
        end else tmr++;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("model_ch_rst_n", 32'(ch_rst_n), 32'(exp_ch(k)));
      chk("model_seq_busy", 32'(seq_busy), 32'(k < N));
      chk("model_seq_done", 32'(seq_done), 32'(m_done));
      chk("model_err",      32'(err_timeout), 32'(m_err));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_ch(input logic [N-1:0] v, input string nm);
    int c;
    c = 0;
    while (ch_rst_n !== v && c < 200) begin step(1); c++; end
    chk(nm, 32'(ch_rst_n), 32'(v));
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (seq_busy !== 1'b0 && c < 200) begin step(1); c++; end
    chk(nm, 32'(seq_busy), 32'd0);
  endtask

  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
  endtask

  initial begin
    compared = 0; mismatched = 0; cmp_en = 1'b0;
    reset = 1'b1; rst_req_async = 1'b0; sw_rst_req = 1'b0; ch_ready = 3'b111;
    step(3);
    cmp_en = 1'b1;
    chk("rst_ch_rst_n", 32'(ch_rst_n), 32'h0);
    chk("rst_busy",     32'(seq_busy), 32'h1);
    chk("rst_done",     32'(seq_done), 32'h0);
    chk("rst_err",      32'(err_timeout), 32'h0);

    // Test 1: synchroniser drains 2 cycles, 4 hold cycles, then 2-cycle gaps.
    reset = 1'b0;
    step(5);  chk("t1_hold",   32'(ch_rst_n), 32'h0);
    step(1);  chk("t1_ch0",    32'(ch_rst_n), 32'h1);
    step(2);  chk("t1_ch1",    32'(ch_rst_n), 32'h3);
    step(2);  chk("t1_ch2",    32'(ch_rst_n), 32'h7);
              chk("t1_busy",   32'(seq_busy), 32'h0);
    step(1);  chk("t1_done_a", 32'(seq_done), 32'h0);
    step(1);  chk("t1_done_b", 32'(seq_done), 32'h1);
    step(1);  chk("t1_done_c", 32'(seq_done), 32'h0);

    // Test 2: ch_ready[1] low for 10 WAIT cycles, below the timeout.
    ch_ready = 3'b101;
    sw_pulse();
    chk("t2_restart", 32'(ch_rst_n), 32'h0);
    wait_ch(3'b011, "t2_ch1");
    step(10); chk("t2_held", 32'(ch_rst_n), 32'h3);
    ch_ready = 3'b111;
    step(1);  chk("t2_release", 32'(ch_rst_n), 32'h7);
              chk("t2_no_err",  32'(err_timeout), 32'h0);
    wait_idle("t2_idle");
    step(2);

    // Test 3: ch_ready[1] stuck low, timeout on the 16th WAIT cycle.
    ch_ready = 3'b101;
    sw_pulse();
    wait_ch(3'b011, "t3_ch1");
    step(15); chk("t3_pre_err",  32'(err_timeout), 32'h0);
              chk("t3_pre_ch",   32'(ch_rst_n), 32'h3);
    step(1);  chk("t3_err",      32'(err_timeout), 32'h2);
              chk("t3_forced",   32'(ch_rst_n), 32'h7);
    wait_idle("t3_idle");
    step(3);
    sw_pulse();
    chk("t3_sticky", 32'(err_timeout), 32'h2);
    chk("t3_reheld", 32'(ch_rst_n), 32'h0);

    // Test 4: software request while 011 restarts from channel 0.
    ch_ready = 3'b111;
    wait_ch(3'b011, "t4_ch1");
    sw_pulse();
    chk("t4_abort",   32'(ch_rst_n), 32'h0);
    chk("t4_busy",    32'(seq_busy), 32'h1);
    step(3);  chk("t4_hold",  32'(ch_rst_n), 32'h0);
    step(1);  chk("t4_ch0",   32'(ch_rst_n), 32'h1);
              chk("t4_err",   32'(err_timeout), 32'h2);

    // Test 5: one-cycle async glitch from RUN.
    wait_idle("t5_idle");
    step(2);
    rst_req_async = 1'b1;
    step(1);
    rst_req_async = 1'b0;
    step(1);  chk("t5_not_yet", 32'(ch_rst_n), 32'h7);
    step(1);  chk("t5_assert",  32'(ch_rst_n), 32'h0);
    step(3);  chk("t5_hold",    32'(ch_rst_n), 32'h0);
    step(1);  chk("t5_ch0",     32'(ch_rst_n), 32'h1);

    // Test 6: global reset mid-WAIT restores reset values and clears errors.
    wait_ch(3'b011, "t6_ch1");
    reset = 1'b1;
    step(1);
    chk("t6_ch",   32'(ch_rst_n), 32'h0);
    chk("t6_busy", 32'(seq_busy), 32'h1);
    chk("t6_done", 32'(seq_done), 32'h0);
    chk("t6_err",  32'(err_timeout), 32'h0);
    reset = 1'b0;
    step(20);
    chk("t6_rerun", 32'(ch_rst_n), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
